// File: rtl/tl_timer_pkg.sv
// Shared phase encodings and default timing for the traffic-light phase timers.
package tl_timer_pkg;

  typedef enum logic [1:0] {
    S0_NS_GREEN  = 2'd0,
    S1_NS_YELLOW = 2'd1,
    S2_EW_GREEN  = 2'd2,
    S3_EW_YELLOW = 2'd3
  } tl_phase_e;

  localparam int GREEN_SECS  = 30;
  localparam int YELLOW_SECS = 3;
  localparam int DEF_CNT_W   = 6;

  localparam logic [4*DEF_CNT_W-1:0] DEF_DUR_TABLE = {
    DEF_CNT_W'(YELLOW_SECS), DEF_CNT_W'(GREEN_SECS),
    DEF_CNT_W'(YELLOW_SECS), DEF_CNT_W'(GREEN_SECS)
  };

  // Headroom for the largest duration plus all extensions.
  function automatic int target_width(input int cnt_w, input int ext_w);
    return cnt_w + ext_w + 3;
  endfunction

endpackage

// File: rtl/phase_target_calc.sv
// Per-phase target length: table select, zero clamp, extension add, illegal detect.
module phase_target_calc
  import tl_timer_pkg::*;
#(
  parameter int NUM_PHASES = 4,
  parameter int PH_W       = 2,
  parameter int CNT_W      = 6,
  parameter int EXT_SECS   = 5,
  parameter int EXT_W      = 2,
  parameter int TGT_W      = target_width(CNT_W, EXT_W)
) (
  input  logic [PH_W-1:0]             phase,
  input  logic [NUM_PHASES*CNT_W-1:0] dur_table,
  input  logic [EXT_W-1:0]            ext_count,
  output logic [TGT_W-1:0]            target,
  output logic                        illegal
);

  logic [CNT_W-1:0] dur_sel;

  always_comb begin
    dur_sel = '0;
    illegal = 1'b1;
    for (int i = 0; i < NUM_PHASES; i++) begin
      if (phase == PH_W'(i)) begin
        dur_sel = dur_table[i*CNT_W +: CNT_W];
        illegal = 1'b0;
      end
    end
    // A zero entry would never expire; treat it as a one-second phase.
    if (dur_sel == '0) dur_sel = CNT_W'(1);
    target = TGT_W'(dur_sel) + TGT_W'(ext_count) * TGT_W'(EXT_SECS);
  end

endmodule

// File: rtl/phase_timer_multi.sv
// Multi-phase traffic timer: elapsed counter, hold, bounded extensions, remaining readout.
module phase_timer_multi
  import tl_timer_pkg::*;
#(
  parameter int NUM_PHASES = 4,
  parameter int PH_W       = 2,
  parameter int CNT_W      = 6,
  parameter int EXT_SECS   = 5,
  parameter int MAX_EXT    = 2,
  parameter int EXT_W      = 2
) (
  input  logic                        clk_1hz,
  input  logic                        rst,
  input  logic [PH_W-1:0]             phase,
  input  logic [NUM_PHASES*CNT_W-1:0] dur_table,
  input  logic                        hold,
  input  logic                        ext_req,
  output logic                        expire,
  output logic [PH_W-1:0]             expire_phase,
  output logic [CNT_W-1:0]            remaining,
  output logic                        ext_ack,
  output logic [EXT_W-1:0]            ext_count,
  output logic                        err
);

  localparam int TGT_W = target_width(CNT_W, EXT_W);
  localparam logic [TGT_W-1:0] REM_MAX = TGT_W'((1 << CNT_W) - 1);

  logic [PH_W-1:0]  prev_phase;
  logic [TGT_W-1:0] elapsed;
  logic [TGT_W-1:0] target;
  logic [TGT_W-1:0] last_sec;
  logic [TGT_W-1:0] left;
  logic             illegal;
  logic             done;

  phase_target_calc #(
    .NUM_PHASES (NUM_PHASES),
    .PH_W       (PH_W),
    .CNT_W      (CNT_W),
    .EXT_SECS   (EXT_SECS),
    .EXT_W      (EXT_W),
    .TGT_W      (TGT_W)
  ) u_calc (
    .phase     (phase),
    .dur_table (dur_table),
    .ext_count (ext_count),
    .target    (target),
    .illegal   (illegal)
  );

  // ">=" so a table entry lowered below elapsed expires at once.
  assign last_sec = target - TGT_W'(1);
  assign done     = (elapsed >= last_sec);

  always_ff @(posedge clk_1hz) begin
    if (rst) begin
      elapsed      <= '0;
      ext_count    <= '0;
      prev_phase   <= phase;
      expire       <= 1'b0;
      expire_phase <= '0;
      ext_ack      <= 1'b0;
      err          <= 1'b0;
    end else begin
      prev_phase <= phase;
      expire     <= 1'b0;
      ext_ack    <= 1'b0;
      err        <= illegal;
      if (illegal || (phase != prev_phase)) begin
        elapsed   <= '0;
        ext_count <= '0;
      end else if (!hold) begin
        if (done) begin
          expire       <= 1'b1;
          expire_phase <= phase;
          elapsed      <= '0;
          ext_count    <= '0;
        end else begin
          elapsed <= elapsed + TGT_W'(1);
          if (ext_req && (int'(ext_count) < MAX_EXT)) begin
            ext_count <= ext_count + EXT_W'(1);
            ext_ack   <= 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    left      = '0;
    remaining = '0;
    if (!err && !done) begin
      left      = last_sec - elapsed;
      remaining = (left > REM_MAX) ? '1 : left[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_phase_timer_multi.sv
// Directed and randomized checks of phase_timer_multi against a behavioural timing model.
module tb_phase_timer_multi;
  import tl_timer_pkg::*;

  localparam int NP = 4, PHW = 3, CW = 6, EXTS = 5, MAXE = 2, EW = 2;

  logic              clk_1hz = 1'b0;
  logic              rst = 1'b1;
  logic [PHW-1:0]    phase = '0;
  logic [NP*CW-1:0]  dur_table = DEF_DUR_TABLE;
  logic              hold = 1'b0;
  logic              ext_req = 1'b0;
  logic              expire;
  logic [PHW-1:0]    expire_phase;
  logic [CW-1:0]     remaining;
  logic              ext_ack;
  logic [EW-1:0]     ext_count;
  logic              err;

  phase_timer_multi #(
    .NUM_PHASES(NP), .PH_W(PHW), .CNT_W(CW),
    .EXT_SECS(EXTS), .MAX_EXT(MAXE), .EXT_W(EW)
  ) dut (
    .clk_1hz(clk_1hz), .rst(rst), .phase(phase), .dur_table(dur_table),
    .hold(hold), .ext_req(ext_req), .expire(expire), .expire_phase(expire_phase),
    .remaining(remaining), .ext_ack(ext_ack), .ext_count(ext_count), .err(err)
  );

  always #5 clk_1hz = ~clk_1hz;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: seconds spent in this visit, extensions granted, last seen phase.
  int secs_in_phase = 0;
  int grants = 0;
  int seen_phase = 0;
  int exp_err = 0, exp_expire = 0, exp_ack = 0, exp_ph = 0;

  function automatic int phase_len(input int p);
    int d;
    if (p >= NP) return 1;
    d = int'(dur_table[p*CW +: CW]);
    return (d == 0) ? 1 : d;
  endfunction

  function automatic int want_remaining();
    int r;
    if (exp_err != 0) return 0;
    r = phase_len(int'(phase)) + grants * EXTS - 1 - secs_in_phase;
    if (r < 0) r = 0;
    if (r > (1 << CW) - 1) r = (1 << CW) - 1;
    return r;
  endfunction

  task automatic model_tick();
    int p, length;
    p = int'(phase);
    exp_expire = 0;
    exp_ack = 0;
    if (rst) begin
      secs_in_phase = 0; grants = 0; exp_err = 0; exp_ph = 0; seen_phase = p;
      return;
    end
    exp_err = (p >= NP) ? 1 : 0;
    length  = phase_len(p) + grants * EXTS;
    if (p >= NP || p != seen_phase) begin
      secs_in_phase = 0; grants = 0;
    end else if (!hold) begin
      if (secs_in_phase + 1 >= length) begin
        exp_expire = 1; exp_ph = p; secs_in_phase = 0; grants = 0;
      end else begin
        secs_in_phase++;
        if (ext_req && grants < MAXE) begin grants++; exp_ack = 1; end
      end
    end
    seen_phase = p;
  endtask

  task automatic chk(input string tag, input int got, input int want);
    n_checks++;
    assert (got === want) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, got, want);
  endtask

  task automatic step();
    model_tick();
    @(posedge clk_1hz);
    #1;
    chk("expire", int'(expire), exp_expire);
    if (exp_expire != 0) chk("expire_phase", int'(expire_phase), exp_ph);
    chk("ext_ack", int'(ext_ack), exp_ack);
    chk("ext_count", int'(ext_count), grants);
    chk("err", int'(err), exp_err);
    chk("remaining", int'(remaining), want_remaining());
  endtask

  // Steps until an expire pulse (bounded); returns the number of steps taken.
  task automatic run_to_expire(input int limit, output int n);
    n = 0;
    while (n < limit) begin
      step();
      n++;
      if (expire) break;
    end
  endtask

  initial begin
    int n, acks;

    // Reset state
    rst = 1'b1;
    phase = PHW'(S0_NS_GREEN);
    dur_table[0*CW +: CW] = 6'd30;
    dur_table[1*CW +: CW] = 6'd3;
    step(); step();
    chk("rst_expire", int'(expire), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_ext_count", int'(ext_count), 0);
    rst = 1'b0;

    // Green 30 s: first expire on the 30th cycle, then every 30
    run_to_expire(40, n);
    chk("first_expire_cycle", n, 30);
    chk("first_expire_phase", int'(expire_phase), 0);
    run_to_expire(40, n);
    chk("second_expire_cycle", n, 30);

    // Switch to yellow (3 s)
    phase = PHW'(S1_NS_YELLOW);
    step();
    chk("yel_no_expire_on_change", int'(expire), 0);
    chk("yel_rem_2", int'(remaining), 2);
    step();
    chk("yel_rem_1", int'(remaining), 1);
    step();
    chk("yel_rem_0", int'(remaining), 0);
    step();
    chk("yel_expire", int'(expire), 1);
    chk("yel_expire_phase", int'(expire_phase), 1);

    // EW green 10 s with three extension requests; only two granted
    dur_table[2*CW +: CW] = 6'd10;
    phase = PHW'(S2_EW_GREEN);
    step();
    n = 0; acks = 0;
    while (n < 40) begin
      ext_req = (secs_in_phase == 4 || secs_in_phase == 6 || secs_in_phase == 8);
      step();
      n++;
      if (ext_ack) acks++;
      if (expire) break;
    end
    ext_req = 1'b0;
    chk("ext_expire_cycle", n, 20);
    chk("ext_acks", acks, 2);

    // Hold freezes timing and ignores extension requests
    dur_table[0*CW +: CW] = 6'd10;
    phase = PHW'(S0_NS_GREEN);
    step();
    n = 0;
    while (secs_in_phase != 7 && n < 20) begin step(); n++; end
    hold = 1'b1; ext_req = 1'b1;
    repeat (5) step();
    chk("hold_remaining", int'(remaining), 2);
    chk("hold_ext_count", int'(ext_count), 0);
    hold = 1'b0; ext_req = 1'b0;
    run_to_expire(20, n);
    chk("post_hold_expire_cycle", n, 3);

    // Extension request colliding with expire: expire wins
    dur_table[0*CW +: CW] = 6'd3;
    step(); step();
    ext_req = 1'b1;
    step();
    chk("collide_expire", int'(expire), 1);
    chk("collide_ack", int'(ext_ack), 0);
    chk("collide_ext_count", int'(ext_count), 0);
    ext_req = 1'b0;

    // Zero duration behaves as one second
    dur_table[0*CW +: CW] = 6'd0;
    repeat (3) begin
      step();
      chk("zero_dur_expire", int'(expire), 1);
    end

    // Illegal phase
    phase = 3'd5;
    step();
    chk("illegal_err", int'(err), 1);
    chk("illegal_remaining", int'(remaining), 0);
    chk("illegal_expire", int'(expire), 0);
    step();

    // Mid-phase reset at elapsed 15
    dur_table[0*CW +: CW] = 6'd30;
    phase = PHW'(S0_NS_GREEN);
    step();
    chk("legal_return_err", int'(err), 0);
    n = 0;
    while (secs_in_phase != 15 && n < 40) begin step(); n++; end
    rst = 1'b1;
    step();
    chk("midrst_expire", int'(expire), 0);
    chk("midrst_ack", int'(ext_ack), 0);
    chk("midrst_ext_count", int'(ext_count), 0);
    chk("midrst_err", int'(err), 0);
    rst = 1'b0;
    run_to_expire(40, n);
    chk("midrst_restart_cycle", n, 30);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 5)       phase = PHW'($urandom_range(0, NP - 1));
      else if (r < 7)  phase = PHW'($urandom_range(NP, 7));
      if ($urandom_range(0, 99) < 4)
        dur_table[$urandom_range(0, NP - 1)*CW +: CW] = CW'($urandom_range(0, 63));
      hold    = ($urandom_range(0, 99) < 15);
      ext_req = ($urandom_range(0, 99) < 25);
      rst     = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0; hold = 1'b0; ext_req = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
